ccip_mem_responder: RTL and testbench



---
 rtl/ccip_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_ccip_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_mem_responder.sv
// CCI-P style memory responder: per-channel request FIFOs feeding a 512-bit line memory.
// Define CCIP_MEM_RSP_STALL_EN to add LFSR-driven pop stalls that exercise backpressure.

module CcipReqFifo #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 8,
    parameter int ALM_FULL_SLACK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    input  logic             stall,
    output logic             popFire,
    output logic [WIDTH-1:0] popData,
    output logic             almFull,
    output logic             overflow
);
    localparam int PW         = $clog2(DEPTH);
    localparam int ALM_THRESH = DEPTH - ALM_FULL_SLACK;

    logic [PW:0]      wrPtr, rdPtr, count, nextCount;
    logic [WIDTH-1:0] store [DEPTH];
    logic             push, full, empty;

    // A push arriving on a full FIFO is dropped even if a pop frees a slot this edge.
    always_comb begin
        count     = wrPtr - rdPtr;
        full      = (count == (PW+1)'(DEPTH));
        empty     = (count == '0);
        push      = pushValid && !full;
        popFire   = !empty && !stall;
        nextCount = count + (PW+1)'(push) - (PW+1)'(popFire);
    end

    assign popData = store[rdPtr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            almFull  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + (PW+1)'(1);
            if (popFire)
                rdPtr <= rdPtr + (PW+1)'(1);
            if (pushValid && full)
                overflow <= 1'b1;
            almFull <= (int'(nextCount) >= ALM_THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            store[wrPtr[PW-1:0]] <= pushData;
    end
endmodule

module ccip_mem_responder #(
    parameter int DEPTH_LOG2     = 6,
    parameter int RD_LATENCY     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALM_FULL_SLACK = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c0_req_valid,
    input  logic [41:0]  c0_req_addr,
    input  logic [15:0]  c0_req_mdata,
    input  logic         c1_req_valid,
    input  logic [41:0]  c1_req_addr,
    input  logic [15:0]  c1_req_mdata,
    input  logic [511:0] c1_req_data,
    output logic         c0_alm_full,
    output logic         c1_alm_full,
    output logic         c0_rsp_valid,
    output logic [15:0]  c0_rsp_mdata,
    output logic [511:0] c0_rsp_data,
    output logic         c1_rsp_valid,
    output logic [15:0]  c1_rsp_mdata,
    output logic [1:0]   ovf_err
);
    localparam int LINES = 1 << DEPTH_LOG2;
    localparam int RD_W  = DEPTH_LOG2 + 16;
    localparam int WR_W  = DEPTH_LOG2 + 16 + 512;

    logic                  rdStall, wrStall;
    logic                  rdPop, wrPop;
    logic                  rdOvf, wrOvf;
    logic [RD_W-1:0]       rdEntry;
    logic [WR_W-1:0]       wrEntry;
    logic [DEPTH_LOG2-1:0] rdIdx, wrIdx;
    logic [15:0]           rdMdata, wrMdata;
    logic [511:0]          wrData;
    logic                  unusedAddrBits;

`ifdef CCIP_MEM_RSP_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; free-running from the fixed seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign rdStall = (lfsr[1:0] == 2'b00);
    assign wrStall = (lfsr[3:2] == 2'b00);
`else
    assign rdStall = 1'b0;
    assign wrStall = 1'b0;
`endif

    // Only the line index is kept; upper address bits alias onto the same lines.
    assign unusedAddrBits = ^{c0_req_addr[41:DEPTH_LOG2], c1_req_addr[41:DEPTH_LOG2]};

    CcipReqFifo #(.WIDTH(RD_W), .DEPTH(FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)) rdFifo (
        .clk      (clk),
        .reset    (reset),
        .pushValid(c0_req_valid),
        .pushData ({c0_req_addr[DEPTH_LOG2-1:0], c0_req_mdata}),
        .stall    (rdStall),
        .popFire  (rdPop),
        .popData  (rdEntry),
        .almFull  (c0_alm_full),
        .overflow (rdOvf)
    );

    CcipReqFifo #(.WIDTH(WR_W), .DEPTH(FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)) wrFifo (
        .clk      (clk),
        .reset    (reset),
        .pushValid(c1_req_valid),
        .pushData ({c1_req_addr[DEPTH_LOG2-1:0], c1_req_mdata, c1_req_data}),
        .stall    (wrStall),
        .popFire  (wrPop),
        .popData  (wrEntry),
        .almFull  (c1_alm_full),
        .overflow (wrOvf)
    );

    assign ovf_err = {wrOvf, rdOvf};
    assign rdIdx   = rdEntry[RD_W-1:16];
    assign rdMdata = rdEntry[15:0];
    assign wrIdx   = wrEntry[WR_W-1:528];
    assign wrMdata = wrEntry[527:512];
    assign wrData  = wrEntry[511:0];

    logic [511:0] mem [LINES];

    always_ff @(posedge clk) begin
        if (wrPop)
            mem[wrIdx] <= wrData;
    end

    logic [RD_LATENCY-1:0]         pipeValid;
    logic [RD_LATENCY-1:0][15:0]   pipeMdata;
    logic [RD_LATENCY-1:0][511:0]  pipeData;

    // The read samples mem with the pre-edge value, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipeValid    <= '0;
            pipeMdata    <= '0;
            pipeData     <= '0;
            c0_rsp_valid <= 1'b0;
            c0_rsp_mdata <= '0;
            c0_rsp_data  <= '0;
        end else begin
            pipeValid[0] <= rdPop;
            pipeMdata[0] <= rdPop ? rdMdata : 16'h0;
            pipeData[0]  <= rdPop ? mem[rdIdx] : 512'h0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeMdata[i] <= pipeMdata[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
            c0_rsp_valid <= pipeValid[RD_LATENCY-1];
            c0_rsp_mdata <= pipeMdata[RD_LATENCY-1];
            c0_rsp_data  <= pipeData[RD_LATENCY-1];
        end
    end

    logic        wrPendValid;
    logic [15:0] wrPendMdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPendValid  <= 1'b0;
            wrPendMdata  <= '0;
            c1_rsp_valid <= 1'b0;
            c1_rsp_mdata <= '0;
        end else begin
            wrPendValid  <= wrPop;
            wrPendMdata  <= wrPop ? wrMdata : 16'h0;
            c1_rsp_valid <= wrPendValid;
            c1_rsp_mdata <= wrPendMdata;
        end
    end
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Bench for ccip_mem_responder: a cycle model of both FIFOs and the memory feeds
// expected-response queues that are matched against the DUT outputs every cycle.

module tb_ccip_mem_responder;
    localparam int RD_LAT = 4;
    localparam int FIFO_D = 8;
    localparam int SLACK  = 2;
`ifdef CCIP_MEM_RSP_STALL_EN
    localparam int BURST  = 40;
`else
    localparam int BURST  = 100;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         c0_req_valid, c1_req_valid;
    logic [41:0]  c0_req_addr, c1_req_addr;
    logic [15:0]  c0_req_mdata, c1_req_mdata;
    logic [511:0] c1_req_data;
    logic         c0_alm_full, c1_alm_full;
    logic         c0_rsp_valid, c1_rsp_valid;
    logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic [1:0]   ovf_err;

    ccip_mem_responder #(
        .DEPTH_LOG2(6), .RD_LATENCY(RD_LAT), .FIFO_DEPTH(FIFO_D), .ALM_FULL_SLACK(SLACK)
    ) dut (
        .clk(clk), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
        .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
        .c1_req_data(c1_req_data),
        .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
        .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
        .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] mdata; logic [5:0] idx; } RdEntry;
    typedef struct { logic [15:0] mdata; logic [5:0] idx; logic [511:0] data; } WrEntry;
    typedef struct { logic [15:0] mdata; logic [511:0] data; int cycle; } RdExp;
    typedef struct { logic [15:0] mdata; int cycle; } WrExp;

    RdEntry       rdFifoModel[$];
    WrEntry       wrFifoModel[$];
    RdExp         rdExpQ[$];
    WrExp         wrExpQ[$];
    logic [511:0] memModel [64];
    logic [1:0]   expOvf;
    int           cycle;
    int           checks;
    int           failures;
`ifdef CCIP_MEM_RSP_STALL_EN
    logic [15:0]  lfsrModel;
`endif

    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Replays the edge that just happened, using the inputs still held from before it.
    task automatic modelEdge();
        logic   stall0, stall1, pop0, pop1, push0, push1;
        RdEntry r;
        WrEntry w;
        RdExp   re;
        WrExp   we;
        cycle++;
        stall0 = 1'b0;
        stall1 = 1'b0;
`ifdef CCIP_MEM_RSP_STALL_EN
        stall0 = (lfsrModel[1:0] == 2'b00);
        stall1 = (lfsrModel[3:2] == 2'b00);
        lfsrModel = {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
`endif
        pop0  = (rdFifoModel.size() > 0) && !stall0;
        pop1  = (wrFifoModel.size() > 0) && !stall1;
        push0 = c0_req_valid && (rdFifoModel.size() < FIFO_D);
        push1 = c1_req_valid && (wrFifoModel.size() < FIFO_D);
        if (c0_req_valid && !push0) expOvf[0] = 1'b1;
        if (c1_req_valid && !push1) expOvf[1] = 1'b1;
        if (pop0) begin
            r = rdFifoModel.pop_front();
            re.mdata = r.mdata;
            re.data  = memModel[r.idx];
            re.cycle = cycle + RD_LAT;
            rdExpQ.push_back(re);
        end
        if (pop1) begin
            w = wrFifoModel.pop_front();
            we.mdata = w.mdata;
            we.cycle = cycle + 1;
            wrExpQ.push_back(we);
            memModel[w.idx] = w.data;
        end
        if (push0) begin
            r.mdata = c0_req_mdata;
            r.idx   = c0_req_addr[5:0];
            rdFifoModel.push_back(r);
        end
        if (push1) begin
            w.mdata = c1_req_mdata;
            w.idx   = c1_req_addr[5:0];
            w.data  = c1_req_data;
            wrFifoModel.push_back(w);
        end
    endtask

    task automatic compareOutputs();
        logic expRd, expWr;
        RdExp re;
        WrExp we;
        checkOutput("c0_alm_full", c0_alm_full, (FIFO_D - rdFifoModel.size()) <= SLACK);
        checkOutput("c1_alm_full", c1_alm_full, (FIFO_D - wrFifoModel.size()) <= SLACK);
        checkOutput("ovf_err", ovf_err, expOvf);
        expRd = 1'b0;
        if (rdExpQ.size() > 0)
            expRd = (rdExpQ[0].cycle == cycle);
        checkOutput("c0_rsp_valid", c0_rsp_valid, expRd);
        if (expRd) begin
            re = rdExpQ.pop_front();
            checkOutput("c0_rsp_mdata", c0_rsp_mdata, re.mdata);
            checkOutput("c0_rsp_data", c0_rsp_data, re.data);
        end else begin
            checkOutput("c0_rsp_data_idle", c0_rsp_data, '0);
        end
        expWr = 1'b0;
        if (wrExpQ.size() > 0)
            expWr = (wrExpQ[0].cycle == cycle);
        checkOutput("c1_rsp_valid", c1_rsp_valid, expWr);
        if (expWr) begin
            we = wrExpQ.pop_front();
            checkOutput("c1_rsp_mdata", c1_rsp_mdata, we.mdata);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            rdFifoModel.delete();
            wrFifoModel.delete();
            rdExpQ.delete();
            wrExpQ.delete();
            expOvf = 2'b00;
            cycle  = 0;
`ifdef CCIP_MEM_RSP_STALL_EN
            lfsrModel = 16'hACE1;
`endif
        end else begin
            modelEdge();
            compareOutputs();
        end
    end

    task automatic applyStimulus(input logic rv, input logic [41:0] ra, input logic [15:0] rm,
                                 input logic wv, input logic [41:0] wa, input logic [15:0] wm,
                                 input logic [511:0] wd);
        @(negedge clk);
        #1;
        c0_req_valid = rv;
        c0_req_addr  = ra;
        c0_req_mdata = rm;
        c1_req_valid = wv;
        c1_req_addr  = wa;
        c1_req_mdata = wm;
        c1_req_data  = wd;
    endtask

    function automatic int pending();
        return rdFifoModel.size() + wrFifoModel.size() + rdExpQ.size() + wrExpQ.size();
    endfunction

    task automatic waitIdle(input int budget);
        int left;
        left = budget;
        applyStimulus(0, '0, '0, 0, '0, '0, '0);
        while (pending() > 0 && left > 0) begin
            applyStimulus(0, '0, '0, 0, '0, '0, '0);
            left--;
        end
        checkOutput("drain", pending(), 0);
    endtask

    function automatic logic [41:0] randAddr(input int lineIdx);
        logic [41:0] a;
        a = {10'($urandom), 32'($urandom)};
        a[5:0] = 6'(lineIdx);
        return a;
    endfunction

    function automatic logic [511:0] randLine();
        logic [511:0] d;
        for (int i = 0; i < 16; i++)
            d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        c0_req_valid = 0; c0_req_addr = '0; c0_req_mdata = '0;
        c1_req_valid = 0; c1_req_addr = '0; c1_req_mdata = '0; c1_req_data = '0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_c0_rsp_valid", c0_rsp_valid, 0);
        checkOutput("rst_c1_rsp_valid", c1_rsp_valid, 0);
        checkOutput("rst_c0_rsp_data", c0_rsp_data, 0);
        checkOutput("rst_c0_alm_full", c0_alm_full, 0);
        checkOutput("rst_c1_alm_full", c1_alm_full, 0);
        checkOutput("rst_ovf_err", ovf_err, 0);
        reset = 1'b1;

        // Write then read line 5 three edges later.
        applyStimulus(0, '0, '0, 1, 42'h5, 16'h11, {16{32'hDEADBEEF}});
        applyStimulus(0, '0, '0, 0, '0, '0, '0);
        applyStimulus(0, '0, '0, 0, '0, '0, '0);
        applyStimulus(1, 42'h5, 16'h22, 0, '0, '0, '0);
        waitIdle(50);

        for (int i = 0; i < 8; i++)
            applyStimulus(0, '0, '0, 1, randAddr(i), 16'(16'h100 + i), randLine());
        waitIdle(50);

        // Address 0x40 aliases onto line 0.
        applyStimulus(0, '0, '0, 1, 42'h40, 16'h36, {16{32'hA5A50F0F}});
        waitIdle(50);
        applyStimulus(1, 42'h0, 16'h37, 0, '0, '0, '0);
        waitIdle(50);

        // Same-edge read and write of line 3: read sees old data.
        applyStimulus(0, '0, '0, 1, 42'h3, 16'h38, {16{32'hBBBB0001}});
        waitIdle(50);
        applyStimulus(1, 42'h3, 16'h39, 1, 42'h3, 16'h3A, {16{32'hCCCC0002}});
        waitIdle(50);
        applyStimulus(1, 42'h3, 16'h3B, 0, '0, '0, '0);
        waitIdle(50);

        for (int i = 0; i < 40; i++)
            applyStimulus(1'($urandom), randAddr($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom), randAddr($urandom_range(0, 7)), 16'($urandom), randLine());
        waitIdle(400);

        for (int i = 0; i < BURST; i++)
            applyStimulus(1, randAddr(i % 8), 16'(i), 0, '0, '0, '0);
        waitIdle(600);

        // Reset in the middle of traffic; nothing in flight may come back.
        for (int i = 0; i < 6; i++)
            applyStimulus(1, randAddr(i % 8), 16'(16'h300 + i), 1, randAddr((i + 3) % 8),
                          16'(16'h400 + i), randLine());
        #1;
        reset = 1'b0;
        c0_req_valid = 0;
        c1_req_valid = 0;
        #1;
        checkOutput("midrst_c0_rsp_valid", c0_rsp_valid, 0);
        checkOutput("midrst_c0_rsp_mdata", c0_rsp_mdata, 0);
        checkOutput("midrst_c0_rsp_data", c0_rsp_data, 0);
        checkOutput("midrst_c1_rsp_valid", c1_rsp_valid, 0);
        checkOutput("midrst_c1_rsp_mdata", c1_rsp_mdata, 0);
        checkOutput("midrst_alm_full", {c1_alm_full, c0_alm_full}, 0);
        checkOutput("midrst_ovf_err", ovf_err, 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (12) applyStimulus(0, '0, '0, 0, '0, '0, '0);

        for (int i = 0; i < 8; i++)
            applyStimulus(1, randAddr(i), 16'(16'h500 + i), 0, '0, '0, '0);
        waitIdle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
